display_arbiter: RTL and testbench

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_arbiter.sv | 79 +++++++
 tb/tb_display_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// display_arbiter: two-requester arbiter with round-robin tie-break and minimum dwell before preemption,
// driving a shared 2:1 data mux with registered select, data and valid.
module display_arbiter #(
    parameter int WIDTH = 4,
    parameter int DWELL = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             done0,
    input  logic             done1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             selection,
    output logic [WIDTH-1:0] out,
    output logic             valid
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             gnt0_q, gnt1_q, valid_q;
    logic             sat, exit0, exit1;

    always_comb begin
        sat   = cnt_q == CMAX;
        exit0 = done0 | ~req0;
        exit1 = done1 | ~req1;
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = (req0 & req1) ? (last_q ? OWN0 : OWN1) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
            OWN0:    state_d = (req1 & (exit0 | sat)) ? OWN1 : exit0 ? IDLE : OWN0;
            OWN1:    state_d = (req0 & (exit1 | sat)) ? OWN0 : exit1 ? IDLE : OWN1;
            default: state_d = IDLE;
        endcase
        // counter restarts on every new grant, including a direct handoff
        cnt_d  = (state_d == IDLE || state_d != state_q) ? '0 : sat ? cnt_q : cnt_q + CW'(1);
        last_d = (state_d == OWN1) ? 1'b1 : (state_d == OWN0) ? 1'b0 : last_q;
        sel_d  = (state_d == OWN1) ? 1'b1 : (state_d == OWN0) ? 1'b0 : sel_q;
        out_d  = (state_d == OWN1) ? d1 : (state_d == OWN0) ? d0 : out_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            out_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            gnt0_q  <= state_d == OWN0;
            gnt1_q  <= state_d == OWN1;
            valid_q <= state_d != IDLE;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign selection = sel_q;
    assign out       = out_q;
    assign valid     = valid_q;
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: scoreboard bench with a behavioural owner/hold-time model plus directed scenarios.
module tb_display_arbiter;
    localparam int W = 4;
    localparam int DW = 8;

    logic clk = 1'b0, reset = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, done0 = 1'b0, done1 = 1'b0;
    logic [W-1:0] d0 = '0, d1 = '0;
    logic gnt0, gnt1, selection, valid;
    logic [W-1:0] out;

    display_arbiter #(.WIDTH(W), .DWELL(DW)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .done0(done0), .done1(done1),
        .d0(d0), .d1(d1), .gnt0(gnt0), .gnt1(gnt1), .selection(selection), .out(out), .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic g0;
        logic g1;
        logic sel;
        logic [W-1:0] dat;
        logic v;
    } exp_t;

    exp_t sb[$];
    int checks = 0, failures = 0;

    int m_own, m_hold;
    logic m_last, m_sel, m_v;
    logic [W-1:0] m_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_hold = 0; m_last = 1'b1; m_sel = 1'b0; m_v = 1'b0; m_out = '0;
        sb.delete();
    endtask

    // predicts the outputs after the coming edge from the inputs currently driven
    task automatic model_push();
        int nxt, me, oth;
        logic rme, dme, roth;
        exp_t e;
        if (m_own < 0) begin
            nxt = (req0 && req1) ? (m_last ? 0 : 1) : req0 ? 0 : req1 ? 1 : -1;
        end else begin
            me = m_own; oth = 1 - m_own;
            rme = me ? req1 : req0;
            dme = me ? done1 : done0;
            roth = oth ? req1 : req0;
            if (roth && (dme || !rme || m_hold >= DW - 1)) nxt = oth;
            else if (dme || !rme) nxt = -1;
            else nxt = me;
        end
        if (nxt >= 0 && nxt != m_own) begin
            m_hold = 0; m_last = (nxt == 1);
        end else if (nxt >= 0) m_hold++;
        else m_hold = 0;
        if (nxt >= 0) m_sel = (nxt == 1);
        if (nxt == 1) m_out = d1;
        else if (nxt == 0) m_out = d0;
        m_v = (nxt >= 0);
        m_own = nxt;
        e.g0 = (nxt == 0); e.g1 = (nxt == 1); e.sel = m_sel; e.dat = m_out; e.v = m_v;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t x;
        model_push();
        @(posedge clk);
        #1;
        chk("sb_depth", sb.size(), 1);
        x = sb.pop_front();
        chk("gnt0", gnt0, x.g0);
        chk("gnt1", gnt1, x.g1);
        chk("selection", selection, x.sel);
        chk("out", out, x.dat);
        chk("valid", valid, x.v);
        chk("exclusive", gnt0 & gnt1, 0);
    endtask

    initial begin
        int n, exp_own;
        model_reset();
        #12;
        chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0); chk("rst_sel", selection, 0);
        chk("rst_out", out, 0); chk("rst_valid", valid, 0);
        @(posedge clk); #1; reset = 1'b0;

        // simultaneous first request: requester 0 wins, then dwell preemption by requester 1
        req0 = 1; req1 = 1; d0 = 4'h3; d1 = 4'h5;
        step();
        chk("tie_gnt0", gnt0, 1); chk("tie_out", out, 4'h3); chk("tie_sel", selection, 0);
        n = 1;
        for (int i = 0; i < 20 && gnt0; i++) begin
            step();
            if (gnt0) n++;
        end
        chk("dwell_len", n, DW);
        chk("handoff_gnt1", gnt1, 1); chk("handoff_valid", valid, 1); chk("handoff_out", out, 4'h5);

        // owner 1 releases with done1 on its third cycle; outputs hold in IDLE
        req0 = 0; d1 = 4'hA;
        step(); step();
        done1 = 1;
        step();
        done1 = 0; req1 = 0;
        chk("rel_valid", valid, 0); chk("rel_out", out, 4'hA); chk("rel_sel", selection, 1);
        step();

        // done from the non-owner is ignored
        req1 = 1;
        step();
        done0 = 1;
        step();
        done0 = 0;
        chk("nonowner_done", gnt1, 1);

        // both held, owner releases every other cycle: grants alternate
        req0 = 1; req1 = 1; exp_own = 1;
        for (int i = 0; i < 12; i++) begin
            done0 = (i % 2 == 1); done1 = (i % 2 == 1);
            step();
            if (i % 2 == 1) exp_own ^= 1;
            chk("alt_gnt1", gnt1, exp_own);
        end
        done0 = 0; done1 = 0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 3) != 0);
            done0 = ($urandom_range(0, 7) == 0);
            done1 = ($urandom_range(0, 7) == 0);
            d0 = W'($urandom); d1 = W'($urandom);
            step();
        end

        // reset mid-grant acts without a clock edge
        req0 = 0; req1 = 0; done0 = 0; done1 = 0;
        step();
        req1 = 1; d1 = 4'hC;
        step();
        chk("pre_rst_gnt1", gnt1, 1);
        #2 reset = 1;
        #1;
        chk("arst_gnt1", gnt1, 0); chk("arst_valid", valid, 0);
        chk("arst_out", out, 0); chk("arst_sel", selection, 0);
        model_reset();
        req1 = 0;
        @(posedge clk); #1; reset = 0;
        req0 = 1; req1 = 1; d0 = 4'h6;
        step();
        chk("restart_gnt0", gnt0, 1);
        req0 = 0; req1 = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
